// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register bridge: register map, CTRL bits,
// command-decoder state encoding and the default ID value.
package spi_reg_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_ID        = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_CTRL      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_BLINK_DIV = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH0  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH1  = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH2  = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH3  = 3'd7;

  localparam int unsigned CTRL_LED_ON   = 0;
  localparam int unsigned CTRL_BLINK_EN = 1;
  localparam int unsigned CTRL_W        = 2;

  localparam logic [DATA_W-1:0] ID_VALUE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

endpackage

// File: rtl/led_blinker.sv
// LED driver: steady level from led_on, or a toggle every
// (div+1) * 2^PRESCALE_W clocks while blinking is enabled.
module led_blinker
  import spi_reg_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              led_on_i,
  input  logic              blink_en_i,
  input  logic [DATA_W-1:0] div_i,
  input  logic              div_restart_i,
  output logic              led_o,
  output logic              phase_o
);

  logic [PRESCALE_W-1:0] pre_q;
  logic [DATA_W-1:0]     cnt_q;
  logic                  led_q;
  logic                  phase_q;

  // Prescaler/divider chain; counters idle at zero whenever blinking is off.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      phase_q <= 1'b0;
    end else if (!blink_en_i) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      led_q   <= led_on_i;
      phase_q <= 1'b0;
    end else if (div_restart_i) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_q + PRESCALE_W'(1);
      if (pre_q == '1) begin
        if (cnt_q == div_i) begin
          cnt_q   <= '0;
          led_q   <= ~led_q;
          phase_q <= ~phase_q;
        end else begin
          cnt_q <= cnt_q + DATA_W'(1);
        end
      end
    end
  end

  assign led_o   = led_q;
  assign phase_o = phase_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI byte-stream command decoder and 8-entry register file.
// Optional build macro SPI_REG_BRIDGE_ERRCNT_EN turns register 4 into a
// read-only saturating count of aborted frames.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter logic [7:0]  ID_VALUE   = ID_VALUE_DEFAULT,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_active,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic [7:0] o_tx_data,
  output logic       o_led,
  output logic       o_frame_done
);

`ifdef SPI_REG_BRIDGE_ERRCNT_EN
  localparam bit ERRCNT_EN = 1'b1;
`else
  localparam bit ERRCNT_EN = 1'b0;
`endif

  state_e              state_q;
  logic                frame_prev_q;
  logic                dir_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   tx_q;
  logic                done_q;
  logic [3:0]          frame_cnt_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [DATA_W-1:0]   div_q;
  logic [DATA_W-1:0]   scratch_q [4];
  logic                blink_phase;

  logic                frame_end_c;
  logic                wr_en_c;
  logic                div_wr_c;
  logic [ADDR_W-1:0]   rd_addr_c;
  logic [DATA_W-1:0]   rd_data_c;
  logic [DATA_W-1:0]   status_c;

`ifdef SPI_REG_BRIDGE_ERRCNT_EN
  logic [DATA_W-1:0]   errcnt_q;
  logic                data_seen_q;
  logic                abort_c;
`endif

  // Frame bookkeeping and write strobes shared by the FSM and register file.
  always_comb begin
    frame_end_c = (state_q != ST_IDLE) && !i_frame_active;
    wr_en_c     = (state_q == ST_DATA) && i_rx_valid && dir_wr_q;
    div_wr_c    = wr_en_c && (addr_q == ADDR_BLINK_DIV);
    rd_addr_c   = (state_q == ST_CMD) ? i_rx_data[ADDR_W-1:0] : addr_q;
    status_c    = {frame_cnt_q, 2'b00, blink_phase, o_led};
  end

  // Register read mux; reflects the values before any write this cycle.
  always_comb begin
    rd_data_c = '0;
    case (rd_addr_c)
      ADDR_ID:        rd_data_c = ID_VALUE;
      ADDR_CTRL:      rd_data_c = DATA_W'(ctrl_q);
      ADDR_BLINK_DIV: rd_data_c = div_q;
      ADDR_STATUS:    rd_data_c = status_c;
`ifdef SPI_REG_BRIDGE_ERRCNT_EN
      ADDR_SCRATCH0:  rd_data_c = errcnt_q;
`else
      ADDR_SCRATCH0:  rd_data_c = scratch_q[rd_addr_c[1:0]];
`endif
      ADDR_SCRATCH1,
      ADDR_SCRATCH2,
      ADDR_SCRATCH3:  rd_data_c = scratch_q[rd_addr_c[1:0]];
      default:        rd_data_c = '0;
    endcase
  end

  // Command decoder: frame edge detect, command latch, auto-increment, tx byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      frame_prev_q <= 1'b1;
      dir_wr_q     <= 1'b0;
      addr_q       <= '0;
      tx_q         <= '0;
      done_q       <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_prev_q <= i_frame_active;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_frame_active && !frame_prev_q) begin
            state_q <= ST_CMD;
            tx_q    <= status_c;
          end
        end
        ST_CMD: begin
          if (i_rx_valid) begin
            state_q  <= ST_DATA;
            dir_wr_q <= i_rx_data[7];
            if (i_rx_data[7]) begin
              addr_q <= i_rx_data[ADDR_W-1:0];
            end else begin
              addr_q <= i_rx_data[ADDR_W-1:0] + ADDR_W'(1);
              tx_q   <= rd_data_c;
            end
          end
        end
        ST_DATA: begin
          if (i_rx_valid) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (!dir_wr_q) begin
              tx_q <= rd_data_c;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // A byte arriving with the frame end is handled above before leaving.
      if (frame_end_c) begin
        state_q     <= ST_IDLE;
        done_q      <= 1'b1;
        frame_cnt_q <= frame_cnt_q + 4'd1;
      end
    end
  end

  // Writable registers; read-only addresses silently drop writes.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ctrl_q <= '0;
      div_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        scratch_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      case (addr_q)
        ADDR_CTRL:      ctrl_q <= i_rx_data[CTRL_W-1:0];
        ADDR_BLINK_DIV: div_q  <= i_rx_data;
        default: begin
          if (addr_q[2] && !(ERRCNT_EN && (addr_q == ADDR_SCRATCH0))) begin
            scratch_q[addr_q[1:0]] <= i_rx_data;
          end
        end
      endcase
    end
  end

`ifdef SPI_REG_BRIDGE_ERRCNT_EN
  // Abort: frame closed with no command byte, or a write command with no data.
  always_comb begin
    abort_c = frame_end_c &&
              (((state_q == ST_CMD) && (!i_rx_valid || i_rx_data[7])) ||
               ((state_q == ST_DATA) && dir_wr_q && !data_seen_q && !i_rx_valid));
  end

  // Saturating abort counter plus the "write data seen" flag it relies on.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      errcnt_q    <= '0;
      data_seen_q <= 1'b0;
    end else begin
      if (abort_c && (errcnt_q != 8'hFF)) begin
        errcnt_q <= errcnt_q + DATA_W'(1);
      end
      if (state_q == ST_CMD) begin
        data_seen_q <= 1'b0;
      end else if (wr_en_c) begin
        data_seen_q <= 1'b1;
      end
    end
  end
`endif

  led_blinker #(
    .PRESCALE_W (PRESCALE_W)
  ) u_blinker (
    .clk_i         (i_clk),
    .rst_ni        (i_rst_n),
    .led_on_i      (ctrl_q[CTRL_LED_ON]),
    .blink_en_i    (ctrl_q[CTRL_BLINK_EN]),
    .div_i         (div_q),
    .div_restart_i (div_wr_c),
    .led_o         (o_led),
    .phase_o       (blink_phase)
  );

  assign o_tx_data    = tx_q;
  assign o_frame_done = done_q;

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Byte-level command decoder and register file directly downstream of the SPI slave byte engine.
- Consumes completed receive bytes and the synchronized chip-select frame flag.
- Decodes a command/address byte followed by data bytes, with auto-increment, into an 8-entry register map.
- Drives the LED (steady or blinking) and presents the next transmit byte back to the SPI slave.

Parameters:
- ID_VALUE, 8'hA5, constant returned by register 0.
- PRESCALE_W, 16, width of the blink prescaler; one blink tick every 2^PRESCALE_W clocks.
- ADDR_W, 3, register address width; fixed at 8 registers, not user-scaled.

Ports:
- i_clk  input  1  system clock, 50 MHz.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_frame_active  input  1  synchronized frame flag; 1 while chip-select is asserted.
- i_rx_valid  input  1  one-cycle pulse when a full byte has been received.
- i_rx_data  input  8  received byte; valid only while i_rx_valid=1.
- o_tx_data  output  8  byte the SPI slave shifts out in the next byte slot.
- o_led  output  1  LED drive.
- o_frame_done  output  1  one-cycle pulse when a frame ends (not in IDLE).

Behaviour:
- Reset: every output and register clears.
  - o_tx_data=0, o_led=0, o_frame_done=0.
  - CTRL=0, BLINK_DIV=0, scratch=0, frame counter=0.
  - State=IDLE; frame_prev=1, so a frame in progress at reset release is ignored.
- Register map:
  - 0 ID: read-only, ID_VALUE.
  - 1 CTRL: bit0 led_on, bit1 blink_en; other bits read 0.
  - 2 BLINK_DIV: R/W.
  - 3 STATUS: read-only; bit0 o_led, bit1 blink phase, bits7:4 frame counter, others 0.
  - 4-7 scratch: R/W.
  - Writes to read-only addresses are ignored; the address still increments.
- Command byte: bit7=1 write, 0 read; bits2:0 start address; bits6:3 ignored.
- FSM:
  - IDLE -> CMD on the rising edge of i_frame_active. o_tx_data<=STATUS in that same cycle (response during the command byte).
  - CMD -> DATA on i_rx_valid: latch dir and addr.
    - Read: o_tx_data<=reg[addr], addr<=addr+1, one cycle after i_rx_valid.
  - DATA, on i_rx_valid:
    - Write: reg[addr]<=i_rx_data, addr<=addr+1.
    - Read: o_tx_data<=reg[addr], addr<=addr+1.
  - CMD/DATA -> IDLE when i_frame_active=0. o_frame_done pulses and the frame counter increments, wrapping mod 16.
- Address wraps 7->0.
- i_rx_valid in IDLE is ignored.
- i_rx_valid in the same cycle as the frame falling: the byte is fully processed first, then the state goes to IDLE.
- Read data is the register value before any write in that cycle.
- Latency: o_tx_data is stable 1 clock after i_rx_valid. This is well within one SCK period.
- LED:
  - blink_en=0: o_led=led_on, registered one cycle after CTRL changes; prescaler and divider counters held at 0.
  - blink_en=1: o_led toggles every (BLINK_DIV+1)*2^PRESCALE_W clocks, starting from the current o_led value. led_on is ignored.
  - Clearing blink_en returns o_led to led_on on the next cycle.
  - A write to BLINK_DIV restarts the divider count.

Optional Feature:
- Macro SPI_REG_BRIDGE_ERRCNT_EN.
- With the macro: register 4 becomes a read-only saturating 8-bit abort counter (saturates at 0xFF, cleared only by reset). It increments when a frame ends in CMD (no command byte) or in DATA with a write and zero data bytes.
- Without the macro: register 4 is ordinary scratch and no counter logic exists.

Decomposition:
- Shared package spi_reg_pkg holds:
  - register address constants (ADDR_ID..ADDR_SCRATCH3);
  - CTRL bit indices;
  - the FSM state encoding (IDLE, CMD, DATA);
  - default ID_VALUE.
- One natural sub-module, led_blinker: prescaler, divider and toggle, with inputs led_on, blink_en, div, div_restart.

Test Plan:
- Reset, then frame with cmd 8'h00 + 2 dummy bytes -> tx sequence STATUS(8'h00), 8'hA5, 8'h00 (CTRL); o_frame_done pulses once; STATUS[7:4]=1 afterwards.
- Write frame 8'h81,8'h01 -> o_led=1 within 2 clocks of frame end; write 8'h81,8'h00 -> o_led=0.
- Write 8'h86,8'h11,8'h22 (addr 6,7) then 8'h11 beyond wrap to addr 0; read back 8'h06 -> 8'h11, 8'h22, then 8'hA5 (wrap to ID; ID unchanged by the write).
- PRESCALE_W=4 in bench: write CTRL=8'h02, BLINK_DIV=8'h02 -> o_led toggles every 48 clocks; clear blink_en -> o_led=led_on next cycle.
- Assert reset mid-write frame after cmd 8'h84 -> regs cleared; subsequent bytes in that frame ignored; next frame decodes normally.
- With SPI_REG_BRIDGE_ERRCNT_EN: 3 frames with no bytes plus one 8'h85-only frame -> reg 4 reads 8'h04; without the macro, reg 4 writes 8'h5A and reads back 8'h5A.
